// File: rtl/noc_host_stream_port.sv
// Host-side PCI stream port for openNocTop: formats outbound words, tracks credits,
// collects returning words into a response FIFO, and runs a host-requested drain.
module noc_host_stream_port #(
  parameter int DATA_W   = 32,
  parameter int X_W      = 4,
  parameter int Y_W      = 4,
  parameter int HOST_X   = 0,
  parameter int HOST_Y   = 0,
  parameter int MAX_OUT  = 8,
  parameter int RX_DEPTH = 8,
  parameter int CNT_W    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [X_W-1:0]              cmd_dst_x,
  input  logic [Y_W-1:0]              cmd_dst_y,
  input  logic [DATA_W-X_W-Y_W-1:0]   cmd_payload,
  output logic                        noc_tx_valid,
  output logic [DATA_W-1:0]           noc_tx_data,
  input  logic                        noc_tx_ready,
  input  logic                        noc_rx_valid,
  input  logic [DATA_W-1:0]           noc_rx_data,
  output logic                        noc_rx_ready,
  output logic                        rsp_valid,
  output logic [DATA_W-X_W-Y_W-1:0]   rsp_data,
  input  logic                        rsp_ready,
  input  logic                        flush_req,
  output logic                        flush_done,
  output logic [CNT_W-1:0]            outstanding,
  output logic [1:0]                  err
);

  localparam int PAY_W = DATA_W - X_W - Y_W;
  localparam int AW    = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DONE} state_e;

  state_e              state_q;
  logic                flush_done_q;

  logic                tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;

  logic [CNT_W-1:0]    out_q, out_d;
  logic [1:0]          err_q, err_d;

  logic [PAY_W-1:0]    mem [RX_DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [AW:0]         count_q, count_d;

  logic                cmd_hs;
  logic                rx_acc;
  logic                rx_hit;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                drained;
  logic [X_W-1:0]      rx_x;
  logic [Y_W-1:0]      rx_y;
  logic [PAY_W-1:0]    rx_pay;

  assign rx_y   = noc_rx_data[DATA_W-1 -: Y_W];
  assign rx_x   = noc_rx_data[DATA_W-Y_W-1 -: X_W];
  assign rx_pay = noc_rx_data[PAY_W-1:0];

  assign fifo_full = (count_q == (AW+1)'(RX_DEPTH));
  assign rx_hit    = (rx_x == X_W'(HOST_X)) && (rx_y == Y_W'(HOST_Y));

  // Combinational readies are forced low while reset is held so every output reads 0.
  assign cmd_ready    = rst && (state_q == S_RUN) && (!tx_valid_q || noc_tx_ready)
                        && (out_q < CNT_W'(MAX_OUT));
  assign noc_rx_ready = rst && !fifo_full;

  assign cmd_hs  = cmd_valid && cmd_ready;
  assign rx_acc  = noc_rx_valid && noc_rx_ready;
  assign push    = rx_acc && rx_hit;
  assign pop     = rsp_valid && rsp_ready;
  assign drained = !tx_valid_q && (out_q == '0) && (count_q == '0);

  assign noc_tx_valid = tx_valid_q;
  assign noc_tx_data  = tx_data_q;
  assign rsp_valid    = (count_q != '0);
  assign rsp_data     = rsp_valid ? mem[rd_ptr_q] : '0;
  assign flush_done   = flush_done_q;
  assign outstanding  = out_q;
  assign err          = err_q;

  // TX output register: load on accept, hold while the NoC stalls, clear when taken.
  always_comb begin
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (cmd_hs) begin
      tx_valid_d = 1'b1;
      tx_data_d  = {cmd_dst_y, cmd_dst_x, cmd_payload};
    end else if (noc_tx_ready) begin
      tx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // Credit counter: dropped returns still free a credit; an unmatched return is an error.
  always_comb begin
    out_d = out_q;
    err_d = err_q;
    if (rx_acc && !rx_hit) begin
      err_d[0] = 1'b1;
    end
    if (cmd_hs && !rx_acc) begin
      out_d = out_q + 1'b1;
    end else if (!cmd_hs && rx_acc) begin
      if (out_q == '0) begin
        err_d[1] = 1'b1;
      end else begin
        out_d = out_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
      err_q <= 2'b00;
    end else begin
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  // Response FIFO bookkeeping; power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= rx_pay;
    end
  end

  // Drain FSM: flush_done is registered alongside the DONE state so it lasts one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_RUN;
      flush_done_q <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          flush_done_q <= 1'b0;
          if (flush_req) begin
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (drained) begin
            state_q      <= S_DONE;
            flush_done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state_q      <= S_RUN;
          flush_done_q <= 1'b0;
        end
        default: begin
          state_q      <= S_RUN;
          flush_done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_host_stream_port.sv
// Randomized and directed bench for noc_host_stream_port against a queue-based reference model.
module tb_noc_host_stream_port;

  localparam int DATA_W   = 32;
  localparam int X_W      = 4;
  localparam int Y_W      = 4;
  localparam int PAY_W    = DATA_W - X_W - Y_W;
  localparam int MAX_OUT  = 8;
  localparam int RX_DEPTH = 8;
  localparam int CNT_W    = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [X_W-1:0]    cmd_dst_x = '0;
  logic [Y_W-1:0]    cmd_dst_y = '0;
  logic [PAY_W-1:0]  cmd_payload = '0;
  logic              noc_tx_valid;
  logic [DATA_W-1:0] noc_tx_data;
  logic              noc_tx_ready = 1'b0;
  logic              noc_rx_valid = 1'b0;
  logic [DATA_W-1:0] noc_rx_data = '0;
  logic              noc_rx_ready;
  logic              rsp_valid;
  logic [PAY_W-1:0]  rsp_data;
  logic              rsp_ready = 1'b0;
  logic              flush_req = 1'b0;
  logic              flush_done;
  logic [CNT_W-1:0]  outstanding;
  logic [1:0]        err;

  noc_host_stream_port #(
    .DATA_W(DATA_W), .X_W(X_W), .Y_W(Y_W), .HOST_X(0), .HOST_Y(0),
    .MAX_OUT(MAX_OUT), .RX_DEPTH(RX_DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dst_x(cmd_dst_x), .cmd_dst_y(cmd_dst_y), .cmd_payload(cmd_payload),
    .noc_tx_valid(noc_tx_valid), .noc_tx_data(noc_tx_data), .noc_tx_ready(noc_tx_ready),
    .noc_rx_valid(noc_rx_valid), .noc_rx_data(noc_rx_data), .noc_rx_ready(noc_rx_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .flush_req(flush_req), .flush_done(flush_done),
    .outstanding(outstanding), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit                m_txv;
  logic [DATA_W-1:0] m_txd;
  int                m_out;
  logic [PAY_W-1:0]  m_q[$];
  logic [1:0]        m_err;
  bit                m_flushing;
  bit                m_done;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_txv = 0; m_txd = '0; m_out = 0; m_q.delete(); m_err = 2'b00;
    m_flushing = 0; m_done = 0;
  endtask

  // One clock: compare all outputs against the model, advance the model, land on next negedge.
  task automatic step();
    bit exp_crdy, exp_rrdy, exp_rv, hs, acc, pop, hit, drained;
    logic [PAY_W-1:0] exp_rd;
    #1;
    exp_crdy = !m_flushing && !m_done && (!m_txv || noc_tx_ready) && (m_out < MAX_OUT);
    exp_rrdy = (m_q.size() < RX_DEPTH);
    exp_rv   = (m_q.size() != 0);
    exp_rd   = exp_rv ? m_q[0] : '0;
    chk("cmd_ready", 64'(cmd_ready), 64'(exp_crdy));
    chk("noc_tx_valid", 64'(noc_tx_valid), 64'(m_txv));
    chk("noc_tx_data", 64'(noc_tx_data), 64'(m_txd));
    chk("noc_rx_ready", 64'(noc_rx_ready), 64'(exp_rrdy));
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    chk("rsp_data", 64'(rsp_data), 64'(exp_rd));
    chk("flush_done", 64'(flush_done), 64'(m_done));
    chk("outstanding", 64'(outstanding), 64'(m_out));
    chk("err", 64'(err), 64'(m_err));

    hs      = cmd_valid && exp_crdy;
    acc     = noc_rx_valid && exp_rrdy;
    pop     = exp_rv && rsp_ready;
    hit     = (noc_rx_data[31:28] == 4'd0) && (noc_rx_data[27:24] == 4'd0);
    drained = !m_txv && (m_out == 0) && (m_q.size() == 0);

    if (pop) void'(m_q.pop_front());
    if (acc && hit) m_q.push_back(noc_rx_data[PAY_W-1:0]);
    if (acc && !hit) m_err[0] = 1'b1;
    if (hs && !acc) m_out = m_out + 1;
    else if (acc && !hs) begin
      if (m_out == 0) m_err[1] = 1'b1;
      else m_out = m_out - 1;
    end
    if (hs) begin
      m_txv = 1;
      m_txd = {cmd_dst_y, cmd_dst_x, cmd_payload};
    end else if (noc_tx_ready) begin
      m_txv = 0;
    end
    if (m_done) m_done = 0;
    else if (m_flushing) begin
      if (drained) begin m_flushing = 0; m_done = 1; end
    end else if (flush_req) m_flushing = 1;

    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop without waiting for a clock.
  task automatic do_reset();
    #3;
    rst = 1'b0;
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_tx_valid", 64'(noc_tx_valid), 64'd0);
    chk("rst_tx_data", 64'(noc_tx_data), 64'd0);
    chk("rst_rx_ready", 64'(noc_rx_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    chk("rst_flush_done", 64'(flush_done), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_outstanding", 64'(outstanding), 64'd0);
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; noc_rx_valid = 0; rsp_ready = 0; flush_req = 0; noc_tx_ready = 1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    idle_inputs();
    do_reset();

    // Single command formatting
    cmd_valid = 1; cmd_dst_x = 4'd2; cmd_dst_y = 4'd1; cmd_payload = 24'h5A5A5A;
    step();
    chk("t1_tx_data", 64'(noc_tx_data), 64'h125A5A5A);
    chk("t1_tx_valid", 64'(noc_tx_valid), 64'd1);
    chk("t1_outstanding", 64'(outstanding), 64'd1);

    // Backpressure with a command pending
    cmd_dst_x = 4'd0; cmd_dst_y = 4'd0; cmd_payload = 24'h111111; noc_tx_ready = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_data", 64'(noc_tx_data), 64'h125A5A5A);
      chk("t2_cmd_ready", 64'(cmd_ready), 64'd0);
    end
    noc_tx_ready = 1;
    step();
    chk("t2_next_data", 64'(noc_tx_data), 64'h00111111);
    chk("t2_outstanding", 64'(outstanding), 64'd2);
    cmd_valid = 0;
    step();
    chk("t2_drained_valid", 64'(noc_tx_valid), 64'd0);

    // Credit limit
    do_reset();
    idle_inputs();
    cmd_valid = 1; cmd_dst_x = 4'd1; cmd_dst_y = 4'd1;
    for (int i = 0; i < 9; i++) begin
      cmd_payload = 24'(i);
      step();
    end
    chk("t3_outstanding_cap", 64'(outstanding), 64'd8);
    chk("t3_cmd_ready_cap", 64'(cmd_ready), 64'd0);
    noc_rx_valid = 1; noc_rx_data = {4'd0, 4'd0, 24'hABCDEF};
    step();
    noc_rx_valid = 0;
    chk("t3_after_return", 64'(outstanding), 64'd7);
    chk("t3_cmd_ready_free", 64'(cmd_ready), 64'd1);
    step();
    chk("t3_ninth_accepted", 64'(outstanding), 64'd8);
    chk("t3_rsp_data", 64'(rsp_data), 64'hABCDEF);

    // Misrouted return and unmatched return
    cmd_valid = 0;
    noc_rx_valid = 1; noc_rx_data = {4'd0, 4'd3, 24'h123456};
    step();
    noc_rx_valid = 0;
    chk("t4_err_misroute", 64'(err), 64'd1);
    chk("t4_outstanding", 64'(outstanding), 64'd7);
    chk("t4_fifo_head", 64'(rsp_data), 64'hABCDEF);
    do_reset();
    idle_inputs();
    noc_rx_valid = 1; noc_rx_data = {4'd0, 4'd0, 24'h000777};
    step();
    noc_rx_valid = 0;
    chk("t4_err_underflow", 64'(err), 64'd2);
    chk("t4_outstanding_zero", 64'(outstanding), 64'd0);

    // Flush handshake
    do_reset();
    idle_inputs();
    cmd_valid = 1; cmd_dst_x = 4'd5; cmd_dst_y = 4'd6;
    for (int i = 0; i < 4; i++) begin
      cmd_payload = 24'(16 + i);
      step();
    end
    cmd_valid = 0; flush_req = 1;
    step();
    flush_req = 0; cmd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      noc_rx_valid = 1; noc_rx_data = {4'd0, 4'd0, 24'(32 + i)};
      step();
      chk("t5_blocked", 64'(cmd_ready), 64'd0);
    end
    noc_rx_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_no_done_yet", 64'(flush_done), 64'd0);
    end
    step();
    chk("t5_done_pulse", 64'(flush_done), 64'd1);
    chk("t5_done_blocked", 64'(cmd_ready), 64'd0);
    step();
    chk("t5_done_clear", 64'(flush_done), 64'd0);
    chk("t5_run_again", 64'(cmd_ready), 64'd1);

    // Randomized traffic with occasional mid-burst resets
    for (int c = 0; c < 3000; c++) begin
      cmd_valid    = ($urandom_range(0, 9) < 6);
      cmd_dst_x    = 4'($urandom);
      cmd_dst_y    = 4'($urandom);
      cmd_payload  = 24'($urandom);
      noc_tx_ready = ($urandom_range(0, 9) < 7);
      noc_rx_valid = ($urandom_range(0, 9) < 4);
      if ($urandom_range(0, 9) < 8) noc_rx_data = {4'd0, 4'd0, 24'($urandom)};
      else noc_rx_data = $urandom;
      rsp_ready    = ($urandom_range(0, 9) < 6);
      flush_req    = ($urandom_range(0, 49) == 0);
      if (c % 700 == 350) do_reset();
      else step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
